// File: rtl/writeback_pkg.sv
// -----------------------------------------------------------------------------
// writeback_pkg
// Shared types for the writeback stage and anything that talks to it:
//   - wb_state_t     : RUN / KILL state of the writeback stage
//   - exec_result_t  : one retiring instruction as produced by execute
//   - EXC_*          : exception cause codes carried in exc_cause
// exec_result_t is sized for the default 32-bit datapath. The writeback
// module itself takes the fields as individual ports so that its XLEN
// parameter stays free.
// -----------------------------------------------------------------------------
package writeback_pkg;

   localparam int PKG_XLEN    = 32;
   localparam int EXC_CAUSE_W = 4;
   localparam int REG_IDX_W   = 5;

   typedef enum logic {
      WB_RUN  = 1'b0,
      WB_KILL = 1'b1
   } wb_state_t;

   typedef struct packed {
      logic [PKG_XLEN-1:0]    pc;
      logic [REG_IDX_W-1:0]   rd_idx;
      logic                   rd_we;
      logic [PKG_XLEN-1:0]    rd_val;
      logic                   br_taken;
      logic [PKG_XLEN-1:0]    br_target;
      logic                   exc;
      logic [EXC_CAUSE_W-1:0] exc_cause;
   } exec_result_t;

   localparam logic [EXC_CAUSE_W-1:0] EXC_INSTR_MISALIGNED = 4'd0;
   localparam logic [EXC_CAUSE_W-1:0] EXC_INSTR_FAULT      = 4'd1;
   localparam logic [EXC_CAUSE_W-1:0] EXC_ILLEGAL_INSTR    = 4'd2;
   localparam logic [EXC_CAUSE_W-1:0] EXC_BREAKPOINT       = 4'd3;
   localparam logic [EXC_CAUSE_W-1:0] EXC_LOAD_MISALIGNED  = 4'd4;
   localparam logic [EXC_CAUSE_W-1:0] EXC_LOAD_FAULT       = 4'd5;
   localparam logic [EXC_CAUSE_W-1:0] EXC_STORE_MISALIGNED = 4'd6;
   localparam logic [EXC_CAUSE_W-1:0] EXC_STORE_FAULT      = 4'd7;
   localparam logic [EXC_CAUSE_W-1:0] EXC_ECALL_U          = 4'd8;
   localparam logic [EXC_CAUSE_W-1:0] EXC_ECALL_M          = 4'd11;

endpackage

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
// Final pipeline stage. Takes one retiring instruction per cycle from execute
// and, one cycle later, produces the register-file write, the matching bypass,
// fetch redirects for taken branches and traps, trap reports to the CSR file
// and the retired-instruction count.
//
// After any redirect the stage enters KILL and drops every wrong-path
// instruction until the one whose pc equals the redirect target shows up.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   i_result_valid              execute presents a retiring instruction
//   o_result_ready              always 1, execute cannot be stalled
//   i_result_*                  fields of the retiring instruction
//   i_mtvec                     trap vector base, low two bits ignored
//   i_instret_we/_wdata         CSR write of the retired-instruction counter
//   o_rf_we/_waddr/_wdata       register-file write port
//   o_fwd_valid/_idx/_val       bypass copy of the register-file write
//   o_redirect_valid/_pc        one-cycle fetch redirect
//   o_trap_valid/_cause/_pc     one-cycle trap report
//   o_instret                   64-bit retired-instruction count
// -----------------------------------------------------------------------------
module writeback
   import writeback_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   i_result_valid,
   output logic                   o_result_ready,
   input  logic [XLEN-1:0]        i_result_pc,
   input  logic [4:0]             i_result_rd_idx,
   input  logic                   i_result_rd_we,
   input  logic [XLEN-1:0]        i_result_rd_val,
   input  logic                   i_result_br_taken,
   input  logic [XLEN-1:0]        i_result_br_target,
   input  logic                   i_result_exc,
   input  logic [3:0]             i_result_exc_cause,

   input  logic [XLEN-1:0]        i_mtvec,

   input  logic                   i_instret_we,
   input  logic [63:0]            i_instret_wdata,

   output logic                   o_rf_we,
   output logic [4:0]             o_rf_waddr,
   output logic [XLEN-1:0]        o_rf_wdata,

   output logic                   o_fwd_valid,
   output logic [4:0]             o_fwd_idx,
   output logic [XLEN-1:0]        o_fwd_val,

   output logic                   o_redirect_valid,
   output logic [XLEN-1:0]        o_redirect_pc,

   output logic                   o_trap_valid,
   output logic [3:0]             o_trap_cause,
   output logic [XLEN-1:0]        o_trap_pc,

   output logic [63:0]            o_instret
);

   wb_state_t         r_state;
   wb_state_t         w_nextState;
   logic [XLEN-1:0]   r_killPc;
   logic [XLEN-1:0]   w_nextKillPc;

   logic              w_accept;
   logic              w_retire;
   logic              w_rfWe;
   logic [4:0]        w_rfWaddr;
   logic [XLEN-1:0]   w_rfWdata;
   logic              w_redirectValid;
   logic [XLEN-1:0]   w_redirectPc;
   logic              w_trapValid;
   logic [3:0]        w_trapCause;
   logic [XLEN-1:0]   w_trapPc;
   logic [XLEN-1:0]   w_trapVector;

   logic              r_rfWe;
   logic [4:0]        r_rfWaddr;
   logic [XLEN-1:0]   r_rfWdata;
   logic              r_redirectValid;
   logic [XLEN-1:0]   r_redirectPc;
   logic              r_trapValid;
   logic [3:0]        r_trapCause;
   logic [XLEN-1:0]   r_trapPc;
   logic [63:0]       r_instret;

   assign o_result_ready = 1'b1;

   assign w_trapVector = {i_mtvec[XLEN-1:2], 2'b00};

   // An instruction is taken seriously either when we are on the correct path
   // already, or when it is exactly the instruction fetch was redirected to.
   always_comb begin
      w_accept = 1'b0;
      case (r_state)
         WB_RUN:  w_accept = i_result_valid;
         WB_KILL: w_accept = i_result_valid && (i_result_pc == r_killPc);
         default: w_accept = 1'b0;
      endcase
   end

   // Next-state and next-output logic. All side effects default to idle and
   // data fields default to zero, so every pulse lasts exactly one cycle and
   // idle cycles show clean zeros. An exception overrides a branch taken in
   // the same instruction. Any redirect re-enters KILL with the new target,
   // including one issued by the instruction that just ended a previous kill.
   always_comb begin
      w_nextState     = r_state;
      w_nextKillPc    = r_killPc;
      w_retire        = 1'b0;
      w_rfWe          = 1'b0;
      w_rfWaddr       = '0;
      w_rfWdata       = '0;
      w_redirectValid = 1'b0;
      w_redirectPc    = '0;
      w_trapValid     = 1'b0;
      w_trapCause     = '0;
      w_trapPc        = '0;

      if (w_accept) begin
         w_nextState = WB_RUN;
         if (i_result_exc) begin
            w_trapValid     = 1'b1;
            w_trapCause     = i_result_exc_cause;
            w_trapPc        = i_result_pc;
            w_redirectValid = 1'b1;
            w_redirectPc    = w_trapVector;
            w_nextState     = WB_KILL;
            w_nextKillPc    = w_trapVector;
         end else begin
            w_retire = 1'b1;
            if (i_result_rd_we && (i_result_rd_idx != 5'd0)) begin
               w_rfWe    = 1'b1;
               w_rfWaddr = i_result_rd_idx;
               w_rfWdata = i_result_rd_val;
            end
            if (i_result_br_taken) begin
               w_redirectValid = 1'b1;
               w_redirectPc    = i_result_br_target;
               w_nextState     = WB_KILL;
               w_nextKillPc    = i_result_br_target;
            end
         end
      end
   end

   // State and kill-target registers. Reset drops any pending kill so the
   // first instruction after reset is always processed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= WB_RUN;
         r_killPc <= '0;
      end else begin
         r_state  <= w_nextState;
         r_killPc <= w_nextKillPc;
      end
   end

   // Output registers: every externally visible effect appears one cycle
   // after the instruction was presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rfWe          <= 1'b0;
         r_rfWaddr       <= '0;
         r_rfWdata       <= '0;
         r_redirectValid <= 1'b0;
         r_redirectPc    <= '0;
         r_trapValid     <= 1'b0;
         r_trapCause     <= '0;
         r_trapPc        <= '0;
      end else begin
         r_rfWe          <= w_rfWe;
         r_rfWaddr       <= w_rfWaddr;
         r_rfWdata       <= w_rfWdata;
         r_redirectValid <= w_redirectValid;
         r_redirectPc    <= w_redirectPc;
         r_trapValid     <= w_trapValid;
         r_trapCause     <= w_trapCause;
         r_trapPc        <= w_trapPc;
      end
   end

   // Retired-instruction counter. Wraps silently at 2^64. A CSR write takes
   // priority over a retirement in the same cycle, so software sees exactly
   // the value it wrote.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instret <= '0;
      end else if (i_instret_we) begin
         r_instret <= i_instret_wdata;
      end else if (w_retire) begin
         r_instret <= r_instret + 64'd1;
      end
   end

   assign o_rf_we          = r_rfWe;
   assign o_rf_waddr       = r_rfWaddr;
   assign o_rf_wdata       = r_rfWdata;
   assign o_fwd_valid      = r_rfWe;
   assign o_fwd_idx        = r_rfWaddr;
   assign o_fwd_val        = r_rfWdata;
   assign o_redirect_valid = r_redirectValid;
   assign o_redirect_pc    = r_redirectPc;
   assign o_trap_valid     = r_trapValid;
   assign o_trap_cause     = r_trapCause;
   assign o_trap_pc        = r_trapPc;
   assign o_instret        = r_instret;

endmodule

// File: tb/tb_writeback.sv
// -----------------------------------------------------------------------------
// tb_writeback
// Directed bench for the writeback stage. A behavioural model tracks whether
// the pipeline is on the wrong path (and which pc ends it), the retired count
// and the expected one-cycle effects; a compare process checks every output
// against it on each falling edge. Literal checks after key vectors pin the
// model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_writeback;
   import writeback_pkg::*;

   logic          clk;
   logic          rst;
   logic          tbValid;
   exec_result_t  tbRes;
   logic [31:0]   tbMtvec;
   logic          tbInstretWe;
   logic [63:0]   tbInstretData;

   logic          resultReady;
   logic          rfWe;
   logic [4:0]    rfWaddr;
   logic [31:0]   rfWdata;
   logic          fwdValid;
   logic [4:0]    fwdIdx;
   logic [31:0]   fwdVal;
   logic          redirectValid;
   logic [31:0]   redirectPc;
   logic          trapValid;
   logic [3:0]    trapCause;
   logic [31:0]   trapPc;
   logic [63:0]   instret;

   int            vectors;
   int            miscompares;
   logic          running;

   logic          mKilling;
   logic [31:0]   mTarget;
   logic [63:0]   mInstret;
   logic          eRfWe;
   logic [4:0]    eRfWaddr;
   logic [31:0]   eRfWdata;
   logic          eRedirectValid;
   logic [31:0]   eRedirectPc;
   logic          eTrapValid;
   logic [3:0]    eTrapCause;
   logic [31:0]   eTrapPc;

   writeback #(.XLEN(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .i_result_valid     (tbValid),
      .o_result_ready     (resultReady),
      .i_result_pc        (tbRes.pc),
      .i_result_rd_idx    (tbRes.rd_idx),
      .i_result_rd_we     (tbRes.rd_we),
      .i_result_rd_val    (tbRes.rd_val),
      .i_result_br_taken  (tbRes.br_taken),
      .i_result_br_target (tbRes.br_target),
      .i_result_exc       (tbRes.exc),
      .i_result_exc_cause (tbRes.exc_cause),
      .i_mtvec            (tbMtvec),
      .i_instret_we       (tbInstretWe),
      .i_instret_wdata    (tbInstretData),
      .o_rf_we            (rfWe),
      .o_rf_waddr         (rfWaddr),
      .o_rf_wdata         (rfWdata),
      .o_fwd_valid        (fwdValid),
      .o_fwd_idx          (fwdIdx),
      .o_fwd_val          (fwdVal),
      .o_redirect_valid   (redirectValid),
      .o_redirect_pc      (redirectPc),
      .o_trap_valid       (trapValid),
      .o_trap_cause       (trapCause),
      .o_trap_pc          (trapPc),
      .o_instret          (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a miss.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic exec_result_t mkRes(input logic [31:0] pc, input logic [4:0] rdIdx,
                                          input logic rdWe, input logic [31:0] rdVal,
                                          input logic br, input logic [31:0] tgt,
                                          input logic exc, input logic [3:0] cause);
      exec_result_t r;
      r.pc        = pc;
      r.rd_idx    = rdIdx;
      r.rd_we     = rdWe;
      r.rd_val    = rdVal;
      r.br_taken  = br;
      r.br_target = tgt;
      r.exc       = exc;
      r.exc_cause = cause;
      return r;
   endfunction

   // Present one input for one cycle; returns on the following falling edge
   // when its effects are visible.
   task automatic applyStimulus(input logic valid, input exec_result_t res);
      tbValid = valid;
      tbRes   = res;
      @(negedge clk);
      tbValid = 1'b0;
   endtask

   // Model: what the outputs must be one cycle after each rising edge.
   // Wrong-path instructions are everything after a redirect up to the one
   // whose pc is the redirect target.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mKilling = 1'b0; mTarget = '0; mInstret = '0;
            eRfWe = 1'b0; eRfWaddr = '0; eRfWdata = '0;
            eRedirectValid = 1'b0; eRedirectPc = '0;
            eTrapValid = 1'b0; eTrapCause = '0; eTrapPc = '0;
         end else begin
            eRfWe = 1'b0; eRfWaddr = '0; eRfWdata = '0;
            eRedirectValid = 1'b0; eRedirectPc = '0;
            eTrapValid = 1'b0; eTrapCause = '0; eTrapPc = '0;
            if (tbValid && (!mKilling || tbRes.pc == mTarget)) begin
               mKilling = 1'b0;
               if (tbRes.exc) begin
                  eTrapValid     = 1'b1;
                  eTrapCause     = tbRes.exc_cause;
                  eTrapPc        = tbRes.pc;
                  eRedirectValid = 1'b1;
                  eRedirectPc    = tbMtvec & 32'hFFFF_FFFC;
                  mKilling       = 1'b1;
                  mTarget        = eRedirectPc;
               end else begin
                  mInstret = mInstret + 64'd1;
                  if (tbRes.rd_we && tbRes.rd_idx != 5'd0) begin
                     eRfWe    = 1'b1;
                     eRfWaddr = tbRes.rd_idx;
                     eRfWdata = tbRes.rd_val;
                  end
                  if (tbRes.br_taken) begin
                     eRedirectValid = 1'b1;
                     eRedirectPc    = tbRes.br_target;
                     mKilling       = 1'b1;
                     mTarget        = tbRes.br_target;
                  end
               end
            end
            if (tbInstretWe) mInstret = tbInstretData;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (running && !rst) begin
            checkOutput("rf_we",          {63'd0, rfWe},          {63'd0, eRfWe});
            checkOutput("rf_waddr",       {59'd0, rfWaddr},       {59'd0, eRfWaddr});
            checkOutput("rf_wdata",       {32'd0, rfWdata},       {32'd0, eRfWdata});
            checkOutput("fwd_valid",      {63'd0, fwdValid},      {63'd0, eRfWe});
            checkOutput("fwd_idx",        {59'd0, fwdIdx},        {59'd0, eRfWaddr});
            checkOutput("fwd_val",        {32'd0, fwdVal},        {32'd0, eRfWdata});
            checkOutput("redirect_valid", {63'd0, redirectValid}, {63'd0, eRedirectValid});
            checkOutput("redirect_pc",    {32'd0, redirectPc},    {32'd0, eRedirectPc});
            checkOutput("trap_valid",     {63'd0, trapValid},     {63'd0, eTrapValid});
            checkOutput("trap_cause",     {60'd0, trapCause},     {60'd0, eTrapCause});
            checkOutput("trap_pc",        {32'd0, trapPc},        {32'd0, eTrapPc});
            checkOutput("instret",        instret,                mInstret);
            checkOutput("result_ready",   {63'd0, resultReady},   64'd1);
         end
      end
   end

   // Directed sequence with hand-computed literal expectations.
   initial begin
      vectors = 0; miscompares = 0; running = 1'b0;
      rst = 1'b1; tbValid = 1'b0; tbInstretWe = 1'b0; tbInstretData = '0;
      tbMtvec = 32'h8000_0003;
      tbRes = mkRes(32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      running = 1'b1;
      @(negedge clk);
      checkOutput("reset rf_we", {63'd0, rfWe}, 64'd0);
      checkOutput("reset instret", instret, 64'd0);
      checkOutput("reset redirect", {63'd0, redirectValid}, 64'd0);
      checkOutput("reset trap", {63'd0, trapValid}, 64'd0);

      applyStimulus(1'b1, mkRes(32'h100, 5'd5, 1'b1, 32'h2A, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("addi rf_we", {63'd0, rfWe}, 64'd1);
      checkOutput("addi waddr", {59'd0, rfWaddr}, 64'd5);
      checkOutput("addi wdata", {32'd0, rfWdata}, 64'h2A);
      checkOutput("addi fwd_val", {32'd0, fwdVal}, 64'h2A);
      checkOutput("addi instret", instret, 64'd1);

      applyStimulus(1'b1, mkRes(32'h104, 5'd0, 1'b1, 32'hFFFF, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("x0 rf_we", {63'd0, rfWe}, 64'd0);
      checkOutput("x0 instret", instret, 64'd2);

      applyStimulus(1'b0, mkRes(32'h108, 5'd6, 1'b1, 32'h66, 1'b1, 32'h900, 1'b1, 4'd3));
      checkOutput("idle trap", {63'd0, trapValid}, 64'd0);
      checkOutput("idle instret", instret, 64'd2);

      applyStimulus(1'b1, mkRes(32'h200, 5'd1, 1'b1, 32'h204, 1'b1, 32'h300, 1'b0, 4'd0));
      checkOutput("br redirect", {63'd0, redirectValid}, 64'd1);
      checkOutput("br redirect_pc", {32'd0, redirectPc}, 64'h300);
      checkOutput("br link we", {63'd0, rfWe}, 64'd1);
      checkOutput("br instret", instret, 64'd3);
      applyStimulus(1'b1, mkRes(32'h204, 5'd6, 1'b1, 32'h66, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("kill1 rf_we", {63'd0, rfWe}, 64'd0);
      checkOutput("kill1 redirect", {63'd0, redirectValid}, 64'd0);
      applyStimulus(1'b1, mkRes(32'h208, 5'd7, 1'b1, 32'h77, 1'b1, 32'h999, 1'b1, 4'd5));
      checkOutput("kill2 trap", {63'd0, trapValid}, 64'd0);
      checkOutput("kill2 instret", instret, 64'd3);
      applyStimulus(1'b0, mkRes(32'h300, 5'd3, 1'b1, 32'h33, 1'b0, 32'h0, 1'b0, 4'd0));
      applyStimulus(1'b1, mkRes(32'h300, 5'd3, 1'b1, 32'h33, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("target waddr", {59'd0, rfWaddr}, 64'd3);
      checkOutput("target instret", instret, 64'd4);
      applyStimulus(1'b1, mkRes(32'h304, 5'd4, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("run again we", {63'd0, rfWe}, 64'd1);
      checkOutput("run again instret", instret, 64'd5);

      applyStimulus(1'b1, mkRes(32'h400, 5'd7, 1'b1, 32'h77, 1'b1, 32'h999, 1'b1, EXC_ILLEGAL_INSTR));
      checkOutput("exc trap_valid", {63'd0, trapValid}, 64'd1);
      checkOutput("exc trap_cause", {60'd0, trapCause}, 64'd2);
      checkOutput("exc trap_pc", {32'd0, trapPc}, 64'h400);
      checkOutput("exc redirect_pc", {32'd0, redirectPc}, 64'h8000_0000);
      checkOutput("exc rf_we", {63'd0, rfWe}, 64'd0);
      checkOutput("exc instret", instret, 64'd5);

      applyStimulus(1'b1, mkRes(32'h8000_0000, 5'd8, 1'b1, 32'h88, 1'b1, 32'h300, 1'b0, 4'd0));
      checkOutput("handler redirect_pc", {32'd0, redirectPc}, 64'h300);
      checkOutput("handler instret", instret, 64'd6);
      applyStimulus(1'b1, mkRes(32'h300, 5'd0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 4'd0));
      checkOutput("rekill redirect_pc", {32'd0, redirectPc}, 64'h500);
      checkOutput("rekill instret", instret, 64'd7);
      applyStimulus(1'b1, mkRes(32'h304, 5'd9, 1'b1, 32'h99, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("rekill drop we", {63'd0, rfWe}, 64'd0);
      checkOutput("rekill drop instret", instret, 64'd7);
      applyStimulus(1'b1, mkRes(32'h500, 5'd9, 1'b1, 32'h99, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("rekill target we", {63'd0, rfWe}, 64'd1);
      checkOutput("rekill target instret", instret, 64'd8);

      applyStimulus(1'b1, mkRes(32'h600, 5'd0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 4'd0));
      checkOutput("pre-reset instret", instret, 64'd9);
      #1;
      rst = 1'b1;
      tbValid = 1'b1;
      tbRes = mkRes(32'h700, 5'd2, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0, 4'd0);
      @(negedge clk);
      tbValid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset instret", instret, 64'd0);
      checkOutput("post-reset rf_we", {63'd0, rfWe}, 64'd0);
      applyStimulus(1'b1, mkRes(32'h10, 5'd1, 1'b1, 32'h11, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("post-reset write", {63'd0, rfWe}, 64'd1);
      checkOutput("post-reset waddr", {59'd0, rfWaddr}, 64'd1);
      checkOutput("post-reset count", instret, 64'd1);

      tbInstretWe = 1'b1;
      tbInstretData = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      tbInstretWe = 1'b0;
      checkOutput("preload instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(1'b1, mkRes(32'h14, 5'd2, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0, 4'd0));
      checkOutput("wrap instret", instret, 64'd0);
      checkOutput("wrap rf_we", {63'd0, rfWe}, 64'd1);

      applyStimulus(1'b0, mkRes(32'h18, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0));
      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter XLEN, default 32: datapath and PC width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 result  decoupled.in  exec_result  retiring instruction from execute; ready is tied to 1 because execute's output is unblockable.
REQ-005 mtvec  input  XLEN  trap vector base; bits [1:0] are ignored and treated as 0.
REQ-006 rf_we / rf_waddr / rf_wdata  output  1 / 5 / XLEN  register-file write port.
REQ-007 fwd_valid / fwd_idx / fwd_val  output  1 / 5 / XLEN  bypass of the value currently being written, equal to the rf_* signals.
REQ-008 redirect_valid / redirect_pc  output  1 / XLEN  single-cycle fetch redirect.
REQ-009 trap_valid / trap_cause / trap_pc  output  1 / 4 / XLEN  single-cycle trap report to the CSR file.
REQ-010 instret  output  64  count of retired instructions.

Function
REQ-011 exec_result fields: pc, rd_idx[4:0], rd_we, rd_val, br_taken, br_target, exc, exc_cause[3:0].
REQ-012 Each valid input is captured into one pipeline register; all outputs are registered, so effects appear exactly 1 cycle after the input cycle.
REQ-013 There are two states, RUN and KILL.
REQ-014 In RUN, a valid input is accepted; with exc=0 it asserts rf_we only if rd_we=1 and rd_idx!=0, and increments instret by 1.
REQ-015 In RUN, exc=1 suppresses rf_we and the instret increment, pulses trap_valid with trap_cause=exc_cause and trap_pc=pc, and pulses redirect_valid with redirect_pc={mtvec[XLEN-1:2],2'b00}.
REQ-016 When exc=1 and br_taken=1 arrive together, exc wins and the branch is ignored.
REQ-017 In RUN, br_taken=1 with exc=0 performs the rd write (JAL/JALR link) and retires normally, and pulses redirect_valid with redirect_pc=br_target.
REQ-018 Any redirect (trap or branch) moves RUN to KILL and latches the redirect target into kill_pc.
REQ-019 In KILL, valid inputs with pc!=kill_pc are discarded: no rf write, no redirect, no trap, no instret change.
REQ-020 In KILL, the first valid input with pc==kill_pc returns to RUN in the same cycle and is processed per REQ-014 to REQ-017; if that input itself redirects, the next state is KILL with the new target.
REQ-021 Cycles with result.valid=0 produce no side effects in either state.
REQ-022 redirect_valid, trap_valid and rf_we are 1-cycle pulses per retiring instruction, never held.
REQ-023 instret wraps from 2^64-1 to 0 without a flag.
REQ-024 Back-to-back valid inputs, one per cycle, are sustained at full throughput.

Reset
REQ-025 On rst, asynchronously: state=RUN, kill_pc=0, instret=0, and all valid/we outputs=0.
REQ-026 On rst, all data outputs are 0.
REQ-027 rst asserted while in KILL abandons the pending kill; the first valid input after reset is processed.
REQ-028 An input presented in the same cycle that rst is asserted is dropped.

Structure
REQ-029 exec_result and the exception-cause constants live in the shared types package.
REQ-030 The wb_state_t enum (RUN/KILL) lives in the shared types package.
REQ-031 The block is a single module with no sub-modules; the instret counter stays inline.

Verification
REQ-032 ADDI retire: pc=0x100, rd_idx=5, rd_val=0x2A -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x2A, fwd_* match, instret 0->1.
REQ-033 x0 write: rd_idx=0, rd_val=0xFFFF -> rf_we=0 and instret increments.
REQ-034 Taken branch: pc=0x200, br_target=0x300 -> redirect_valid=1, redirect_pc=0x300; then inputs with pc=0x204 and 0x208 are dropped; then an input with pc=0x300 and rd_idx=3 writes x3 and state=RUN.
REQ-035 Exception with branch: pc=0x400, exc=1, cause=2, br_taken=1, mtvec=0x80000003 -> trap_valid=1, trap_cause=2, trap_pc=0x400, redirect_pc=0x80000000, no rf write, instret unchanged.
REQ-036 Redirect at kill target: in KILL with kill_pc=0x300, input pc=0x300 taken to 0x500 -> redirect_pc=0x500, state stays KILL with kill_pc=0x500.
REQ-037 Reset during KILL: assert rst, then present pc=0x10 with rd_idx=1 -> rf_we=1; instret starts at 0 and reaches 1, and wraps to 0 when preloaded to 2^64-1.
